write_back_stage: RTL

Final pipeline stage that drives the register-file write port (`write_back_en`, `dest_wb`, `result_wb`) from completed MEM-stage operations. It accepts one op per cycle from the MEM stage, waits for variable-latency data-memory read responses, and issues exactly one registered write per writing op. It also exports pending-destination information for ID-stage hazard detection.

---
 rtl/write_back_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/write_back_stage.sv
// write_back_stage
//   Final pipeline stage. Accepts completed ops from MEM, waits for
//   variable-latency load data, and issues one registered register-file
//   write per writing op. Writes to R15 are redirected to fetch via pc_wb.
//   Also exports the pending destination for ID-stage hazard checks.
//
// Ports
//   clk, rst               clock, synchronous active-low reset
//   mem_valid/mem_ready    MEM-stage handshake
//   mem_wb_en, mem_r_en    op writes a register / op is a load
//   mem_dest, mem_alu_result  destination and non-load result
//   dmem_rdata_valid, dmem_rdata  load response
//   write_back_en, dest_wb, result_wb  register-file write port
//   pc_wb                  one-cycle pulse for a write targeting R15
//   busy_valid, busy_dest  pending destination for hazard detection
//   load_timeout           sticky: a load never got its data
module write_back_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [3:0]        mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              dmem_rdata_valid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              write_back_en,
  output logic [3:0]        dest_wb,
  output logic [DATA_W-1:0] result_wb,
  output logic              pc_wb,
  output logic              busy_valid,
  output logic [3:0]        busy_dest,
  output logic              load_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic               wen_nx, pc_nx, to_nx;
  logic [3:0]         dwb_nx, bd_nx;
  logic [DATA_W-1:0]  res_nx;

  // Handshake and hazard flag depend on state only.
  assign mem_ready  = (state != WAIT);
  assign busy_valid = (state != IDLE);
  assign cnt_inc    = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      write_back_en <= 1'b0;
      pc_wb         <= 1'b0;
      dest_wb       <= '0;
      result_wb     <= '0;
      busy_dest     <= '0;
      load_timeout  <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      write_back_en <= wen_nx;
      pc_wb         <= pc_nx;
      dest_wb       <= dwb_nx;
      result_wb     <= res_nx;
      busy_dest     <= bd_nx;
      load_timeout  <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wen_nx   = 1'b0;
    pc_nx    = 1'b0;
    dwb_nx   = dest_wb;     // write port holds last written values
    res_nx   = result_wb;
    bd_nx    = busy_dest;
    to_nx    = load_timeout;
    case (state)
      // WRITE accepts like IDLE so ALU ops stream back-to-back.
      IDLE, WRITE: begin
        state_nx = IDLE;
        bd_nx    = '0;
        if (mem_valid && mem_wb_en) begin
          bd_nx = mem_dest;
          if (mem_r_en) begin
            state_nx = WAIT;
            cnt_nx   = '0;
          end else begin
            state_nx = WRITE;
            wen_nx   = (mem_dest != PC_REG);
            pc_nx    = (mem_dest == PC_REG);
            dwb_nx   = mem_dest;
            res_nx   = mem_alu_result;
          end
        end
      end
      WAIT: begin
        // Data arriving on the final allowed edge still wins over timeout.
        if (dmem_rdata_valid) begin
          state_nx = WRITE;
          wen_nx   = (busy_dest != PC_REG);
          pc_nx    = (busy_dest == PC_REG);
          dwb_nx   = busy_dest;
          res_nx   = dmem_rdata;
        end else if (cnt_inc == TO_VAL) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          bd_nx    = '0;
          to_nx    = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
